mitm_control: RTL and testbench

// - SPI man-in-the-middle core: sits between an SPI master and slave and

---
 rtl/mitm_control.sv | 136 +++++++++++++
 tb/tb_mitm_control.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mitm_control.sv
// SPI man-in-the-middle: resynchronizes and forwards {ss,sclk,mosi,miso}, snoops words.
// Define MITM_MOSI_TAMPER_EN to XOR the forwarded MOSI stream with TAMPER_MASK.

module mitm_sync_line #(
  parameter int STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) ff <= '0;
    else      ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

module mitm_control #(
  parameter int                   DATA_SIZE   = 8,
  parameter int                   BUS_WIDTH   = 4,
  parameter int                   SYNC_STAGES = 2,
  parameter logic [DATA_SIZE-1:0] TAMPER_MASK = {DATA_SIZE{1'b1}}
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic miso_in,
  input  logic mosi_in,
  input  logic sclk_in,
  input  logic ss_in,
  output logic miso_out,
  output logic mosi_out,
  output logic sclk_out,
  output logic ss_out
);
  localparam int CW    = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam int L_SS  = 3;
  localparam int L_SCK = 2;
  localparam int L_MO  = 1;
  localparam int L_MI  = 0;

  if (SYNC_STAGES < 2 || BUS_WIDTH != 4 || $bits(TAMPER_MASK) != DATA_SIZE) begin : g_bad_cfg
    $error("mitm_control: unsupported parameter set");
  end

  logic [BUS_WIDTH-1:0] bus_in, bus_sync;
  assign bus_in = {ss_in, sclk_in, mosi_in, miso_in};

  for (genvar g = 0; g < BUS_WIDTH; g++) begin : g_lane
    mitm_sync_line #(.STAGES(SYNC_STAGES)) u_sync (
      .sys_clk (sys_clk),
      .rst     (rst),
      .d       (bus_in[g]),
      .q       (bus_sync[g])
    );
  end

  logic ss, sclk, mosi, miso;
  assign ss   = bus_sync[L_SS];
  assign sclk = bus_sync[L_SCK];
  assign mosi = bus_sync[L_MO];
  assign miso = bus_sync[L_MI];

  logic ss_prev, sclk_prev;
  logic sclk_rise, ss_rise, ss_fall;
  assign sclk_rise = sclk & ~sclk_prev;
  assign ss_rise   = ss & ~ss_prev;
  assign ss_fall   = ~ss & ss_prev;

  logic [CW-1:0]        bit_cnt;
  logic [DATA_SIZE-1:0] rx_mosi, rx_miso, cap_mosi, cap_miso;
  logic                 cap_valid;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      ss_prev   <= 1'b0;
      sclk_prev <= 1'b0;
      bit_cnt   <= '0;
      rx_mosi   <= '0;
      rx_miso   <= '0;
      cap_mosi  <= '0;
      cap_miso  <= '0;
      cap_valid <= 1'b0;
    end else begin
      ss_prev   <= ss;
      sclk_prev <= sclk;
      cap_valid <= 1'b0;
      // ss_rise is checked first so an SCLK edge coincident with SS rising is dropped
      if (ss_rise) begin
        bit_cnt <= '0;
        rx_mosi <= '0;
        rx_miso <= '0;
      end else if (ss_fall) begin
        bit_cnt <= '0;
      end else if (sclk_rise && ss) begin
        rx_mosi <= {rx_mosi[DATA_SIZE-2:0], mosi};
        rx_miso <= {rx_miso[DATA_SIZE-2:0], miso};
        if (bit_cnt == CW'(DATA_SIZE-1)) begin
          cap_mosi  <= {rx_mosi[DATA_SIZE-2:0], mosi};
          cap_miso  <= {rx_miso[DATA_SIZE-2:0], miso};
          cap_valid <= 1'b1;
          bit_cnt   <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  logic mosi_fwd;
`ifdef MITM_MOSI_TAMPER_EN
  // bit_cnt counts edges already taken, so it indexes the bit now on the wire
  logic [CW-1:0] bit_idx;
  assign bit_idx  = CW'(DATA_SIZE-1) - bit_cnt;
  assign mosi_fwd = ss ? (mosi ^ TAMPER_MASK[bit_idx]) : mosi;
`else
  assign mosi_fwd = mosi;
`endif

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      miso_out <= 1'b0;
      mosi_out <= 1'b0;
      sclk_out <= 1'b0;
      ss_out   <= 1'b0;
    end else begin
      miso_out <= miso;
      mosi_out <= mosi_fwd;
      sclk_out <= sclk;
      ss_out   <= ss;
    end
  end
endmodule

// File: tb/tb_mitm_control.sv
// Self-checking bench for mitm_control: line replay, word capture scoreboard, corner sequences.
module tb_mitm_control;
  localparam int HALF = 10;
`ifdef MITM_MOSI_TAMPER_EN
  localparam logic [7:0] TX_XOR = 8'hFF;
`else
  localparam logic [7:0] TX_XOR = 8'h00;
`endif

  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  logic miso_in = 1'b0, mosi_in = 1'b0, sclk_in = 1'b0, ss_in = 1'b0;
  logic miso_out, mosi_out, sclk_out, ss_out;

  mitm_control dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .miso_in  (miso_in),
    .mosi_in  (mosi_in),
    .sclk_in  (sclk_in),
    .ss_in    (ss_in),
    .miso_out (miso_out),
    .mosi_out (mosi_out),
    .sclk_out (sclk_out),
    .ss_out   (ss_out)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] miso;
    int         nbits;
    logic [7:0] cap_mosi;
    logic [7:0] cap_miso;
  } vec_t;

  logic [15:0] capq[$];
  logic [7:0]  txq[$];
  int          pulses = 0;
  bit          chk_en = 1'b0;

  // capture scoreboard
  always @(posedge sys_clk) begin : mon_cap
    logic [15:0] e;
    #1;
    if (rst && dut.cap_valid) begin
      pulses++;
      if (capq.size() == 0) check("cap_unexpected", 1, 0);
      else begin
        e = capq.pop_front();
        check("sb_cap_mosi", dut.cap_mosi, e[15:8]);
        check("sb_cap_miso", dut.cap_miso, e[7:0]);
      end
    end
  end

  // per-cycle replay of the lines, 3 cycles delayed
  logic [3:0] hist0 = '0, hist1 = '0;
  always @(posedge sys_clk) begin
    #1;
    if (chk_en) begin
      check("ss_out", ss_out, hist1[3]);
      check("sclk_out", sclk_out, hist1[2]);
      check("miso_out", miso_out, hist1[0]);
`ifdef MITM_MOSI_TAMPER_EN
      if (!hist1[3]) check("mosi_out_idle", mosi_out, hist1[1]);
`else
      check("mosi_out", mosi_out, hist1[1]);
`endif
    end
    hist1 = hist0;
    hist0 = {ss_in, sclk_in, mosi_in, miso_in};
  end

  // forwarded MOSI word, sampled on forwarded SCLK rises within a forwarded frame
  logic [7:0] txw = '0;
  int         txn = 0;
  logic       ss_po = 1'b0, sclk_po = 1'b0;
  always @(posedge sys_clk) begin
    #1;
    if (ss_out && ss_po && sclk_out && !sclk_po) begin
      txw = {txw[6:0], mosi_out};
      txn++;
    end
    if (!ss_out && ss_po) begin
      if (txn == 8) begin
        if (txq.size() == 0) check("tx_unexpected", 1, 0);
        else check("mosi_word", txw, txq.pop_front());
      end
      txn = 0;
    end
    ss_po   = ss_out;
    sclk_po = sclk_out;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #3;
  endtask

  task automatic send_frame(input logic [7:0] m, input logic [7:0] s, input int nbits, input bit glitch);
    if (nbits == 8) begin
      capq.push_back({m, s});
      txq.push_back(m ^ TX_XOR);
    end
    if (glitch) begin
      mosi_in = 1'b1; miso_in = 1'b1; ss_in = 1'b1; sclk_in = 1'b1;
      cyc(HALF);
      sclk_in = 1'b0;
    end else begin
      ss_in = 1'b1;
    end
    cyc(HALF);
    for (int i = 0; i < nbits; i++) begin
      mosi_in = m[7-i];
      miso_in = s[7-i];
      cyc(HALF);
      sclk_in = 1'b1;
      cyc(HALF);
      sclk_in = 1'b0;
    end
    cyc(HALF);
    ss_in = 1'b0; mosi_in = 1'b0; miso_in = 1'b0;
    cyc(HALF);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   p0;
    logic [7:0] a5;
    vecs[0] = '{8'hE7, 8'h3A, 8, 8'hE7, 8'h3A};
    vecs[1] = '{8'hF1, 8'h29, 8, 8'hF1, 8'h29};
    vecs[2] = '{8'hA5, 8'h2B, 8, 8'hA5, 8'h2B};
    vecs[3] = '{8'hE7, 8'hC3, 5, 8'hA5, 8'h2B};
    vecs[4] = '{8'h5C, 8'h91, 8, 8'h5C, 8'h91};

    #2 rst = 1'b0;
    cyc(4);
    check("rst_ss_out", ss_out, 0);
    check("rst_sclk_out", sclk_out, 0);
    check("rst_mosi_out", mosi_out, 0);
    check("rst_miso_out", miso_out, 0);
    check("rst_cap_mosi", dut.cap_mosi, 0);
    check("rst_cap_miso", dut.cap_miso, 0);
    check("rst_cap_valid", dut.cap_valid, 0);
    rst = 1'b1;
    cyc(5);
    chk_en = 1'b1;

    // latency: output follows on the third edge
    ss_in = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 check("lat_early", ss_out, 0);
    @(posedge sys_clk);
    #1 check("lat_3", ss_out, 1);
    #2 ss_in = 1'b0;
    cyc(HALF);

    for (int v = 0; v < 5; v++) begin
      p0 = pulses;
      send_frame(vecs[v].mosi, vecs[v].miso, vecs[v].nbits, 1'b0);
      check($sformatf("v%0d_pulses", v), pulses - p0, (vecs[v].nbits == 8) ? 1 : 0);
      check($sformatf("v%0d_cap_mosi", v), dut.cap_mosi, vecs[v].cap_mosi);
      check($sformatf("v%0d_cap_miso", v), dut.cap_miso, vecs[v].cap_miso);
      check($sformatf("v%0d_bit_cnt", v), dut.bit_cnt, 0);
    end

    // SCLK rising together with SS must not count
    p0 = pulses;
    send_frame(8'h3C, 8'h96, 8, 1'b1);
    check("glitch_pulses", pulses - p0, 1);
    check("glitch_cap_mosi", dut.cap_mosi, 8'h3C);
    check("glitch_cap_miso", dut.cap_miso, 8'h96);

    // reset in the middle of a frame
    a5 = 8'hA5;
    ss_in = 1'b1;
    cyc(HALF);
    for (int i = 0; i < 3; i++) begin
      mosi_in = a5[7-i];
      miso_in = ~a5[7-i];
      cyc(HALF);
      sclk_in = 1'b1;
      cyc(HALF);
      sclk_in = 1'b0;
    end
    cyc(2);
    chk_en = 1'b0;
    rst = 1'b0;
    #1;
    check("mrst_ss_out", ss_out, 0);
    check("mrst_sclk_out", sclk_out, 0);
    check("mrst_mosi_out", mosi_out, 0);
    check("mrst_miso_out", miso_out, 0);
    check("mrst_cap_mosi", dut.cap_mosi, 0);
    check("mrst_cap_miso", dut.cap_miso, 0);
    check("mrst_cap_valid", dut.cap_valid, 0);
    check("mrst_bit_cnt", dut.bit_cnt, 0);
    ss_in = 1'b0; mosi_in = 1'b0; miso_in = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(5);
    chk_en = 1'b1;
    p0 = pulses;
    send_frame(8'hA5, 8'h5A, 8, 1'b0);
    check("post_rst_pulses", pulses - p0, 1);
    check("post_rst_cap_mosi", dut.cap_mosi, 8'hA5);
    check("post_rst_cap_miso", dut.cap_miso, 8'h5A);

    cyc(5);
    check("capq_drained", capq.size(), 0);
    check("txq_drained", txq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
